// File: rtl/lb_reg_responder_if.sv
// Localbus signal bundle between the mem_gateway master and a register responder.
interface lb_reg_responder_if;
  logic [23:0] addr;
  logic        control_strobe;
  logic        control_rd;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        rd_valid;
  logic        hit;

  modport master (
    output addr, control_strobe, control_rd, data_out,
    input  data_in, rd_valid, hit
  );

  modport slave (
    input  addr, control_strobe, control_rd, data_out,
    output data_in, rd_valid, hit
  );
endinterface

// File: rtl/lb_reg_responder.sv
// Localbus register responder: scratch register bank with fixed read latency.
// Define LB_RESP_STATS_EN to map read/write counters onto the two top offsets.
module lb_reg_responder #(
  parameter int          read_pipe_len = 4,
  parameter logic [23:0] base          = 24'h010000,
  parameter int          nreg_lg       = 4,
  parameter logic [31:0] miss_val      = 32'hbad0add0
) (
  input logic               clk,
  input logic               rst_n,
  lb_reg_responder_if.slave lb
);

  localparam int NREG = 1 << nreg_lg;

  logic                 in_win;
  logic [nreg_lg-1:0]   offset;
  logic                 rd_stb;
  logic                 wr_stb;
  logic                 wr_en;
  logic [31:0]          rd_word;

  logic [31:0]          regs_q [NREG];
  logic [31:0]          regs_d [NREG];
  logic                 hit_q;
  logic                 hit_d;
  logic                 pipe_vld_q  [read_pipe_len];
  logic                 pipe_vld_d  [read_pipe_len];
  logic [31:0]          pipe_data_q [read_pipe_len];
  logic [31:0]          pipe_data_d [read_pipe_len];

  assign in_win = (lb.addr[23:nreg_lg] == base[23:nreg_lg]);
  assign offset = lb.addr[nreg_lg-1:0];
  assign rd_stb = lb.control_strobe &  lb.control_rd;
  assign wr_stb = lb.control_strobe & ~lb.control_rd;

`ifdef LB_RESP_STATS_EN
  localparam logic [nreg_lg-1:0] RD_CNT_OFF = '1;
  localparam logic [nreg_lg-1:0] WR_CNT_OFF = {{(nreg_lg-1){1'b1}}, 1'b0};

  logic [31:0] rd_cnt_q;
  logic [31:0] rd_cnt_d;
  logic [31:0] wr_cnt_q;
  logic [31:0] wr_cnt_d;

  // Top two offsets are the counters and cannot be written by the master.
  assign wr_en = wr_stb & in_win & (offset < WR_CNT_OFF);

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_stb && in_win) rd_cnt_d = rd_cnt_q + 32'd1;
    if (wr_stb && in_win) wr_cnt_d = wr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end
`else
  assign wr_en = wr_stb & in_win;
`endif

  // Read sample uses current register state, so it sees every write from earlier cycles.
  always_comb begin
    rd_word = miss_val;
    if (in_win) begin
      rd_word = regs_q[offset];
`ifdef LB_RESP_STATS_EN
      if (offset == RD_CNT_OFF)      rd_word = rd_cnt_q;
      else if (offset == WR_CNT_OFF) rd_word = wr_cnt_q;
`endif
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[offset] = lb.data_out;
    hit_d = lb.control_strobe ? in_win : hit_q;
  end

  always_comb begin
    pipe_vld_d[0]  = rd_stb;
    pipe_data_d[0] = rd_word;
    for (int i = 1; i < read_pipe_len; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      for (int i = 0; i < read_pipe_len; i++) pipe_vld_q[i] <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      pipe_vld_q <= pipe_vld_d;
      hit_q      <= hit_d;
    end
  end

  // Data lanes carry no reset; the output gate below hides stale contents.
  always_ff @(posedge clk) begin
    pipe_data_q <= pipe_data_d;
  end

  assign lb.rd_valid = pipe_vld_q[read_pipe_len-1];
  assign lb.data_in  = pipe_vld_q[read_pipe_len-1] ? pipe_data_q[read_pipe_len-1] : 32'd0;
  assign lb.hit      = hit_q;

endmodule

// File: tb/tb_lb_reg_responder.sv
// Directed bench for lb_reg_responder: latency-4 instance plus a latency-1 instance.
module tb_lb_reg_responder;

  localparam int          L    = 4;
  localparam logic [23:0] BASE = 24'h010000;
`ifdef LB_RESP_STATS_EN
  localparam int NCHK = 14;
`else
  localparam int NCHK = 16;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  lb_reg_responder_if bus ();
  lb_reg_responder_if bus1 ();

  lb_reg_responder #(.read_pipe_len(L)) dut (
    .clk(clk), .rst_n(rst_n), .lb(bus)
  );

  lb_reg_responder #(.read_pipe_len(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .lb(bus1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.control_strobe = 1'b0;
    bus.control_rd     = 1'b0;
  endtask

  task automatic wr(input logic [23:0] a, input logic [31:0] d);
    bus.addr = a; bus.data_out = d;
    bus.control_strobe = 1'b1; bus.control_rd = 1'b0;
    tick();
    idle();
  endtask

  // Single read: quiet for L-1 cycles, one valid cycle at N+L, quiet after.
  task automatic rd_check(input logic [23:0] a, input logic [31:0] exp,
                          input logic exp_hit, input string tag);
    bus.addr = a;
    bus.control_strobe = 1'b1; bus.control_rd = 1'b1;
    tick();
    idle();
    chk({tag, " hit"}, {31'd0, bus.hit}, {31'd0, exp_hit});
    for (int i = 1; i < L; i++) begin
      chk({tag, " early rd_valid"}, {31'd0, bus.rd_valid}, 32'd0);
      chk({tag, " early data_in"}, bus.data_in, 32'd0);
      tick();
    end
    chk({tag, " rd_valid"}, {31'd0, bus.rd_valid}, 32'd1);
    chk({tag, " data_in"}, bus.data_in, exp);
    tick();
    chk({tag, " rd_valid after"}, {31'd0, bus.rd_valid}, 32'd0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] d1 [4];
    bus.addr = '0; bus.data_out = '0; bus.control_strobe = 1'b0; bus.control_rd = 1'b0;
    bus1.addr = '0; bus1.data_out = '0; bus1.control_strobe = 1'b0; bus1.control_rd = 1'b0;

    // Reset state
    #12;
    chk("reset rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("reset data_in", bus.data_in, 32'd0);
    chk("reset hit", {31'd0, bus.hit}, 32'd0);
    tick();
    #2 rst_n = 1'b1;

    // Write then read on the very next cycle
    wr(BASE + 24'd3, 32'h12345678);
    rd_check(BASE + 24'd3, 32'h12345678, 1'b1, "wr_then_rd");

    // Burst: 8 writes then 8 back-to-back reads
    for (int i = 0; i < 8; i++) begin
      bus.addr = BASE + 24'(i);
      bus.data_out = 32'(i) * 32'h11111111;
      bus.control_strobe = 1'b1; bus.control_rd = 1'b0;
      tick();
    end
    for (int c = 0; c <= 12; c++) begin
      if (c >= 4 && c < 12) begin
        chk($sformatf("burst rd_valid c%0d", c), {31'd0, bus.rd_valid}, 32'd1);
        chk($sformatf("burst data c%0d", c), bus.data_in, 32'(c - 4) * 32'h11111111);
      end else begin
        chk($sformatf("burst quiet c%0d", c), {31'd0, bus.rd_valid}, 32'd0);
        chk($sformatf("burst quiet data c%0d", c), bus.data_in, 32'd0);
      end
      if (c < 8) begin
        bus.addr = BASE + 24'(c);
        bus.control_strobe = 1'b1; bus.control_rd = 1'b1;
      end else begin
        idle();
      end
      tick();
    end

    // Out-of-window read and write
    rd_check(24'h020005, 32'hbad0add0, 1'b0, "miss_rd");
    wr(24'h020005, 32'hdeadbeef);
    chk("miss_wr hit", {31'd0, bus.hit}, 32'd0);
    for (int i = 0; i < NCHK; i++) begin
      v = (i < 8) ? 32'(i) * 32'h11111111 : 32'd0;
      rd_check(BASE + 24'(i), v, 1'b1, $sformatf("after_miss off%0d", i));
    end
`ifndef LB_RESP_STATS_EN
    wr(BASE + 24'd15, 32'hcafef00d);
    rd_check(BASE + 24'd15, 32'hcafef00d, 1'b1, "scratch off15");
`endif

    // Reset with three reads in flight
    for (int i = 1; i <= 3; i++) begin
      bus.addr = BASE + 24'(i);
      bus.control_strobe = 1'b1; bus.control_rd = 1'b1;
      tick();
    end
    idle();
    tick();
    chk("inflight rd_valid", {31'd0, bus.rd_valid}, 32'd1);
    chk("inflight data_in", bus.data_in, 32'h11111111);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("async rst data_in", bus.data_in, 32'd0);
    chk("async rst hit", {31'd0, bus.hit}, 32'd0);
    tick();
    chk("in rst rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    tick();
    chk("in rst rd_valid 2", {31'd0, bus.rd_valid}, 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < NCHK; i++) begin
      rd_check(BASE + 24'(i), 32'd0, 1'b1, $sformatf("post_rst off%0d", i));
    end

`ifdef LB_RESP_STATS_EN
    // Counters
    do_reset();
    for (int i = 0; i < 5; i++) wr(BASE + 24'(i), 32'h100 + 32'(i));
    for (int i = 0; i < 3; i++) rd_check(BASE + 24'(i), 32'h100 + 32'(i), 1'b1, "stats scratch");
    rd_check(BASE + 24'd15, 32'd3, 1'b1, "rd_cnt");
    rd_check(BASE + 24'd14, 32'd5, 1'b1, "wr_cnt");
    wr(BASE + 24'd15, 32'hffffffff);
    rd_check(BASE + 24'd15, 32'd5, 1'b1, "rd_cnt ro");
`endif

    // Latency-1 instance: alternating write/read on one offset
    for (int k = 0; k < 4; k++) d1[k] = 32'ha5a50000 + 32'(k);
    for (int c = 0; c <= 8; c++) begin
      if (c >= 2 && (c % 2) == 0) begin
        chk($sformatf("lat1 rd_valid c%0d", c), {31'd0, bus1.rd_valid}, 32'd1);
        chk($sformatf("lat1 data c%0d", c), bus1.data_in, d1[c/2 - 1]);
      end else begin
        chk($sformatf("lat1 quiet c%0d", c), {31'd0, bus1.rd_valid}, 32'd0);
        chk($sformatf("lat1 quiet data c%0d", c), bus1.data_in, 32'd0);
      end
      if (c < 8) begin
        bus1.addr = BASE + 24'd6;
        bus1.control_strobe = 1'b1;
        bus1.control_rd = (c % 2) == 1;
        if ((c % 2) == 0) bus1.data_out = d1[c/2];
      end else begin
        bus1.control_strobe = 1'b0;
        bus1.control_rd = 1'b0;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
